// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write ports of the program loader.
// The master is the host/memory side and the slave is the loader.
interface mem_loader_if #(
  parameter int IMEM_AW = 7,
  parameter int DMEM_AW = 7
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [7:0]         dmem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/mem_loader.sv
// Framed byte-stream loader for the instruction/data memories of the core.
// It holds the core in reset until a RUN command is received.
module mem_loader #(
  parameter int IMEM_AW = 7,
  parameter int DMEM_AW = 7
) (
  input  logic       clk,
  input  logic       reset,
  mem_loader_if.slave bus,
  output logic       core_reset,
  output logic       busy,
  output logic       err
);
  localparam logic [7:0] CMD_IMEM = 8'hA0;
  localparam logic [7:0] CMD_DMEM = 8'hA1;
  localparam logic [7:0] CMD_RUN  = 8'hA5;

  typedef enum logic [2:0] {IDLE, ADR0, ADR1, LEN0, LEN1, DATA, RUN} state_t;

  state_t      state, state_nx;
  logic [15:0] addr, len;
  logic [1:0]  lane;
  logic [31:0] wbuf, word_nx;
  logic        is_imem, xfer, last, word_done, imem_ok, dmem_ok;
  logic        imem_we_d, dmem_we_d, err_set;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign last      = (len == 16'd1);
  assign word_done = (lane == 2'd3) || last;
  assign imem_ok   = ((addr >> IMEM_AW) == 16'd0);
  assign dmem_ok   = ((addr >> DMEM_AW) == 16'd0);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    if (xfer) begin
      case (state)
        IDLE: begin
          if (bus.in_data == CMD_IMEM || bus.in_data == CMD_DMEM) state_nx = ADR0;
          else if (bus.in_data == CMD_RUN)                        state_nx = RUN;
        end
        ADR0: state_nx = ADR1;
        ADR1: state_nx = LEN0;
        LEN0: state_nx = LEN1;
        LEN1: state_nx = ({bus.in_data, len[7:0]} == 16'd0) ? IDLE : DATA;
        DATA: if (last) state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // The incoming byte is merged into the word buffer at its lane; upper lanes stay zero.
  always_comb begin
    word_nx = wbuf;
    word_nx[{lane, 3'b000} +: 8] = bus.in_data;
    imem_we_d = 1'b0;
    dmem_we_d = 1'b0;
    err_set   = 1'b0;
    if (xfer) begin
      if (state == IDLE)
        err_set = (bus.in_data != CMD_IMEM) && (bus.in_data != CMD_DMEM) && (bus.in_data != CMD_RUN);
      else if (state == DATA) begin
        if (is_imem) begin
          imem_we_d = word_done && imem_ok;
          err_set   = word_done && !imem_ok;
        end else begin
          dmem_we_d = dmem_ok;
          err_set   = !dmem_ok;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.in_ready   <= 1'b1;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      core_reset     <= 1'b1;
      busy           <= 1'b0;
      err            <= 1'b0;
      addr           <= '0;
      len            <= '0;
      lane           <= '0;
      wbuf           <= '0;
      is_imem        <= 1'b0;
    end else begin
      bus.in_ready <= (state_nx != RUN);
      core_reset   <= (state_nx != RUN);
      busy         <= (state_nx != IDLE) && (state_nx != RUN);
      bus.imem_we  <= imem_we_d;
      bus.dmem_we  <= dmem_we_d;
      if (err_set) err <= 1'b1;
      if (imem_we_d) begin
        bus.imem_addr  <= addr[IMEM_AW-1:0];
        bus.imem_wdata <= word_nx;
      end
      if (dmem_we_d) begin
        bus.dmem_addr  <= addr[DMEM_AW-1:0];
        bus.dmem_wdata <= bus.in_data;
      end
      if (xfer) begin
        case (state)
          IDLE: begin
            lane    <= '0;
            wbuf    <= '0;
            is_imem <= (bus.in_data == CMD_IMEM);
          end
          ADR0: addr[7:0]  <= bus.in_data;
          ADR1: addr[15:8] <= bus.in_data;
          LEN0: len[7:0]   <= bus.in_data;
          LEN1: len[15:8]  <= bus.in_data;
          DATA: begin
            len <= len - 16'd1;
            if (!is_imem) addr <= addr + 16'd1;
            else if (word_done) begin
              addr <= addr + 16'd1;
              lane <= '0;
              wbuf <= '0;
            end else begin
              lane <= lane + 2'd1;
              wbuf <= word_nx;
            end
          end
          default: ;
        endcase
      end
    end
endmodule

// File: doc/mem_loader.md
# mem_loader

Hardware program loader for the single-cycle RISC-V core, doing in silicon what the simulation flow does with memory preloads. It accepts a framed byte stream over a valid/ready interface and writes instruction memory (32-bit words) and data memory (bytes). The core is held in reset throughout loading. A RUN command releases the core. The block sits between the host byte link and the write ports of the instruction and data memories.

## Interface
- IMEM_AW, 7, instruction-memory word-address width (depth 2^IMEM_AW words)
- DMEM_AW, 7, data-memory byte-address width (depth 2^DMEM_AW bytes)

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  IMEM_AW  instruction word address
- imem_wdata  out  32  instruction word
- dmem_we  out  1  data-memory write strobe, one cycle per byte
- dmem_addr  out  DMEM_AW  data byte address
- dmem_wdata  out  8  data byte
- core_reset  out  1  reset to the core; high until RUN is executed
- busy  out  1  high while a frame is in progress (any state other than IDLE or RUN)
- err  out  1  sticky error flag; cleared only by reset

## Operation
- Handshake: a byte transfers on any rising edge with in_valid && in_ready.
  - in_ready=1 in every state except RUN.
  - No other stall source exists.
- Frame format: CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN payload bytes. ADDR and LEN are 16-bit, little-endian.
- Commands:
  - 0xA0: load IMEM. ADDR is a word index. Payload bytes are packed little-endian (first byte goes to [7:0]).
  - 0xA1: load DMEM. ADDR is a byte index.
  - 0xA5: RUN. Single byte, no fields.
- States: IDLE → ADR0 → ADR1 → LEN0 → LEN1 → DATA → IDLE; IDLE → RUN on 0xA5.
  - Any other CMD byte in IDLE: set err, remain in IDLE.
- LEN=0: LEN1 returns directly to IDLE; no writes occur.
- Address counter:
  - 16 bits, loaded from ADDR.
  - IMEM: increments after each word. DMEM: increments after each byte.
  - Wraps modulo 2^16.
- Out-of-range writes: if the counter is ≥ 2^IMEM_AW (IMEM) or ≥ 2^DMEM_AW (DMEM), the write strobe is suppressed and err is set. The payload is still consumed.
- IMEM word packing:
  - A byte lane counter 0..3 selects the lane. The word is written when lane 3 is filled.
  - If LEN is not a multiple of 4, the final 1–3 bytes are written as one zero-padded word on the last payload byte.
  - The lane counter and word buffer clear at every frame start.
- RUN: core_reset goes low, in_ready goes low. RUN is terminal until reset.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, core_reset=1, busy=0, err=0.
  - imem_we=0, dmem_we=0, all address and data outputs 0.
- Outputs are registered.
- Write strobes:
  - dmem_we is asserted in the cycle after the payload byte handshake, for exactly 1 cycle, with addr and wdata valid in that same cycle.
  - imem_we follows the same rule, keyed to the completing byte.
  - Back-to-back bytes produce back-to-back strobes; no write is dropped.
- Gaps in in_valid freeze all state; no strobes occur during gaps.
- core_reset falls in the cycle after the 0xA5 handshake; in_ready falls in that same cycle.
- busy rises in the cycle after the CMD handshake. It falls in the cycle after the LEN1 handshake when LEN=0, otherwise after the last payload byte.
- err rises in the cycle after the offending handshake.
- Asynchronous reset mid-frame: all outputs return to reset values immediately. No partial word is written. A subsequent frame starts clean.

## Test plan
- Reset: assert reset for 2 cycles.
  - Required: core_reset=1, in_ready=1, err=0, busy=0, no strobes.
- IMEM load: send A0 00 00 08 00 13 05 70 00 93 02 05 00.
  - Required: imem_we pulses twice, with addr 0 / 0x00700513, then addr 1 / 0x00050293.
  - Required: busy low afterwards, err=0.
- DMEM load with backpressure gaps: send A1 04 00 02 00 0F 07, with in_valid idle 3 cycles between bytes.
  - Required: dmem writes addr 4 = 0x0F and addr 5 = 0x07, each a 1-cycle strobe.
- Partial IMEM word: send A0 10 00 03 00 AA BB CC.
  - Required: a single write, addr 0x10, data 0x00CCBBAA.
- Errors:
  - Send byte 0x55 in IDLE. Required: err=1, state stays IDLE.
  - Then send A1 80 00 01 00 FF with DMEM_AW=7. Required: no dmem_we, frame consumed, busy returns to 0.
  - A following A1 00 00 01 00 11 frame still writes addr 0 = 0x11, and err remains 1.
- RUN and reset mid-frame:
  - Send A5. Required: core_reset=0 and in_ready=0 the next cycle.
  - Assert reset, send A0 00 00 04 00 01 02, then reset again. Required: no imem_we, core_reset=1.
